kf8255_bus_sequencer: RTL and testbench

//  Bus master for one KF8255 PPI. Issues the power-up control-word write, then

---
 rtl/kf8255_ctrl_pkg.sv | 32 +++
 rtl/kf8255_bus_sequencer_if.sv | 29 ++
 rtl/kf8255_rr_arbiter.sv | 40 ++++
 rtl/kf8255_bus_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_kf8255_bus_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/kf8255_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : kf8255_ctrl_pkg
// Brief  : Shared state encoding and KF8255 register addresses.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package kf8255_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT_STB = 3'd0,
        ST_INIT_REC = 3'd1,
        ST_IDLE     = 3'd2,
        ST_STB      = 3'd3,
        ST_REC      = 3'd4
    } seq_state_e;

    localparam logic [1:0] PORT_A  = 2'b00;
    localparam logic [1:0] PORT_B  = 2'b01;
    localparam logic [1:0] PORT_C  = 2'b10;
    localparam logic [1:0] CONTROL = 2'b11;

    localparam int PHASE_W = 4;

    // Phase counter counts down to zero, so a phase of N clocks loads N-1.
    function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
        return PHASE_W'(cycles - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/kf8255_bus_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : kf8255_bus_sequencer_if
// Brief  : Two-requester host request/acknowledge bundle.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface kf8255_bus_sequencer_if;

    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][1:0]  req_address;
    logic [1:0][7:0]  req_data;
    logic [1:0]       req_ack;
    logic [7:0]       read_data;

    modport master (
        output req_valid, req_write, req_address, req_data,
        input  req_ack, read_data
    );

    modport slave (
        input  req_valid, req_write, req_address, req_data,
        output req_ack, read_data
    );

endinterface

`default_nettype wire

// File: rtl/kf8255_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module : kf8255_rr_arbiter
// Brief  : Two-way round-robin grant; pointer advances on grant_taken.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module kf8255_rr_arbiter (
    input  wire logic       clock,
    input  wire logic       reset_n,
    input  wire logic [1:0] req_valid,
    input  wire logic       grant_taken,
    output logic            grant_any,
    output logic            grant_idx
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_any = |req_valid;
        // Pointer only matters on contention; a lone requester always wins.
        grant_idx = (&req_valid) ? ptr_q : req_valid[1];
        ptr_d     = ptr_q;
        if (grant_taken) begin
            ptr_d = ~grant_idx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/kf8255_bus_sequencer.sv
//------------------------------------------------------------------------------
// Module : kf8255_bus_sequencer
// Brief  : KF8255 bus master: power-up control write, then round-robin
//          strobe/recovery accesses for two host requesters.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module kf8255_bus_sequencer
    import kf8255_ctrl_pkg::*;
#(
    parameter logic [7:0] INIT_CONTROL_WORD = 8'h80,
    parameter bit         INIT_ENABLE       = 1'b1,
    parameter int         STROBE_CYCLES     = 1,
    parameter int         RECOVERY_CYCLES   = 1
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    kf8255_bus_sequencer_if.slave host,
    output logic              init_done,
    output logic              chip_select_n,
    output logic              read_enable_n,
    output logic              write_enable_n,
    output logic [1:0]        address,
    output logic [7:0]        data_bus_in,
    input  wire logic [7:0]   data_bus_out
);

    localparam logic [PHASE_W-1:0] STB_LOAD = phase_load(STROBE_CYCLES);
    localparam logic [PHASE_W-1:0] REC_LOAD = phase_load(RECOVERY_CYCLES);

    seq_state_e          state_q, state_d;
    logic [PHASE_W-1:0]  cnt_q, cnt_d;
    logic                cs_n_q, cs_n_d;
    logic                rd_n_q, rd_n_d;
    logic                wr_n_q, wr_n_d;
    logic [1:0]          addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [1:0]          ack_q, ack_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                init_done_q, init_done_d;
    logic                gnt_q, gnt_d;
    logic                write_q, write_d;

    logic                grant_taken;
    logic                grant_any;
    logic                grant_idx;

    kf8255_rr_arbiter u_arb (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (host.req_valid),
        .grant_taken (grant_taken),
        .grant_any   (grant_any),
        .grant_idx   (grant_idx)
    );

    // Strobe levels are computed for the state being entered so that every
    // pin comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cs_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ack_d       = 2'b00;
        rdata_d     = rdata_q;
        init_done_d = init_done_q;
        gnt_d       = gnt_q;
        write_d     = write_q;
        grant_taken = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!init_done_q) begin
                    if (INIT_ENABLE) begin
                        state_d = ST_INIT_STB;
                        cnt_d   = STB_LOAD;
                        cs_n_d  = 1'b0;
                        wr_n_d  = 1'b0;
                        addr_d  = CONTROL;
                        wdata_d = INIT_CONTROL_WORD;
                    end else begin
                        init_done_d = 1'b1;
                    end
                end else if (grant_any) begin
                    grant_taken = 1'b1;
                    state_d     = ST_STB;
                    cnt_d       = STB_LOAD;
                    gnt_d       = grant_idx;
                    write_d     = host.req_write[grant_idx];
                    addr_d      = host.req_address[grant_idx];
                    wdata_d     = host.req_data[grant_idx];
                    cs_n_d      = 1'b0;
                    rd_n_d      = host.req_write[grant_idx];
                    wr_n_d      = ~host.req_write[grant_idx];
                end
            end
            ST_INIT_STB: begin
                if (cnt_q == '0) begin
                    state_d = ST_INIT_REC;
                    cnt_d   = REC_LOAD;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    cs_n_d = 1'b0;
                    wr_n_d = 1'b0;
                end
            end
            ST_INIT_REC: begin
                if (cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STB: begin
                if (cnt_q == '0) begin
                    state_d      = ST_REC;
                    cnt_d        = REC_LOAD;
                    ack_d[gnt_q] = 1'b1;
                    if (!write_q) begin
                        rdata_d = data_bus_out;
                    end
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    cs_n_d = 1'b0;
                    rd_n_d = write_q;
                    wr_n_d = ~write_q;
                end
            end
            ST_REC: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            addr_q      <= 2'b00;
            wdata_q     <= 8'h00;
            ack_q       <= 2'b00;
            rdata_q     <= 8'h00;
            init_done_q <= 1'b0;
            gnt_q       <= 1'b0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            init_done_q <= init_done_d;
            gnt_q       <= gnt_d;
            write_q     <= write_d;
        end
    end

    assign chip_select_n  = cs_n_q;
    assign read_enable_n  = rd_n_q;
    assign write_enable_n = wr_n_q;
    assign address        = addr_q;
    assign data_bus_in    = wdata_q;
    assign init_done      = init_done_q;
    assign host.req_ack   = ack_q;
    assign host.read_data = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_kf8255_bus_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_kf8255_bus_sequencer
// Brief  : Two sequencer configurations driven by random requesters and checked
//          against a transaction-timing model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_kf8255_bus_sequencer;
    import kf8255_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    bit   found;

    always #5 clk = ~clk;

    task automatic chk(input int i, input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) begin
            passed++;
        end else begin
            $display("FAIL inst%0d %s: got %0h expected %0h at %0t", i, nm, a, e, $time);
        end
    endtask

    // Vector layout: cs rd wr | addr[2] | dbi[8] | ack[2] | rdata[8] | init
    task automatic cmp(input int i, input int n, input int tg,
                       input logic [23:0] e, input logic [23:0] a);
        int s;
        int r;
        s = (i == 0) ? 1 : 3;
        r = (i == 0) ? 1 : 2;
        chk(i, "chip_select_n",  a[23],    e[23]);
        chk(i, "read_enable_n",  a[22],    e[22]);
        chk(i, "write_enable_n", a[21],    e[21]);
        chk(i, "address",        a[20:19], e[20:19]);
        chk(i, "data_bus_in",    a[18:11], e[18:11]);
        chk(i, "req_ack",        a[10:9],  e[10:9]);
        chk(i, "read_data",      a[8:1],   e[8:1]);
        chk(i, "init_done",      a[0],     e[0]);
        if (n == 1) begin
            chk(i, "init_cs_low",   a[23],    1'b0);
            chk(i, "init_wr_low",   a[21],    1'b0);
            chk(i, "init_addr",     a[20:19], 2'b11);
            chk(i, "init_word",     a[18:11], 8'h80);
        end
        if (n == s + 1)     chk(i, "init_strobe_end", a[23], 1'b1);
        if (n == s + r)     chk(i, "init_done_early", a[0],  1'b0);
        if (n == s + r + 1) chk(i, "init_done_rise",  a[0],  1'b1);
        if (tg == 0) begin
            chk(i, "lit_wr_data", a[18:11], 8'h55);
            chk(i, "lit_wr_ack",  a[10:9],  2'b01);
        end
        if (tg == 1) begin
            chk(i, "lit_ctrl_addr", a[20:19], 2'b11);
            chk(i, "lit_ctrl_data", a[18:11], 8'h90);
            chk(i, "lit_ctrl_ack",  a[10:9],  2'b10);
        end
        if (tg == 2) begin
            chk(i, "lit_rd_data", a[8:1],  8'hA5);
            chk(i, "lit_rd_ack",  a[10:9], 2'b01);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int S = (g == 0) ? 1 : 3;
        localparam int R = (g == 0) ? 1 : 2;

        kf8255_bus_sequencer_if bus_if ();
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       init_done;
        logic [1:0] address;
        logic [7:0] dbi;
        logic [7:0] dbo;
        wire  [23:0] act_vec;

        kf8255_bus_sequencer #(
            .INIT_CONTROL_WORD (8'h80),
            .INIT_ENABLE       (1'b1),
            .STROBE_CYCLES     (S),
            .RECOVERY_CYCLES   (R)
        ) u_dut (
            .clock          (clk),
            .reset_n        (rst_n),
            .host           (bus_if),
            .init_done      (init_done),
            .chip_select_n  (cs_n),
            .read_enable_n  (rd_n),
            .write_enable_n (wr_n),
            .address        (address),
            .data_bus_in    (dbi),
            .data_bus_out   (dbo)
        );

        assign act_vec = {cs_n, rd_n, wr_n, address, dbi, bus_if.req_ack, bus_if.read_data, init_done};

        // Requesters: a short directed script first, then random traffic.
        int tag [2];
        int sp;
        initial begin
            bus_if.req_valid   = 2'b00;
            bus_if.req_write   = 2'b00;
            bus_if.req_address = '0;
            bus_if.req_data    = '0;
            tag = '{-1, -1};
            sp  = 0;
            dbo = 8'h00;
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    for (int r = 0; r < 2; r++) begin
                        if (bus_if.req_ack[r]) begin
                            bus_if.req_valid[r] = 1'b0;
                            tag[r] = -1;
                            if (sp < 3) sp++;
                        end
                    end
                    if (sp < 3) begin
                        if (bus_if.req_valid == 2'b00) begin
                            case (sp)
                                0: begin
                                    bus_if.req_write[0] = 1'b1; bus_if.req_address[0] = PORT_A;
                                    bus_if.req_data[0] = 8'h55; bus_if.req_valid[0] = 1'b1; tag[0] = 0;
                                end
                                1: begin
                                    bus_if.req_write[1] = 1'b1; bus_if.req_address[1] = CONTROL;
                                    bus_if.req_data[1] = 8'h90; bus_if.req_valid[1] = 1'b1; tag[1] = 1;
                                end
                                default: begin
                                    bus_if.req_write[0] = 1'b0; bus_if.req_address[0] = PORT_A;
                                    bus_if.req_data[0] = 8'h00; bus_if.req_valid[0] = 1'b1; tag[0] = 2;
                                end
                            endcase
                        end
                    end else begin
                        for (int r = 0; r < 2; r++) begin
                            if (!bus_if.req_valid[r] && !bus_if.req_ack[r] && $urandom_range(0, 3) != 0) begin
                                bus_if.req_write[r]   = 1'($urandom_range(0, 1));
                                bus_if.req_address[r] = 2'($urandom_range(0, 3));
                                bus_if.req_data[r]    = 8'($urandom);
                                bus_if.req_valid[r]   = 1'b1;
                                tag[r] = -1;
                            end
                        end
                    end
                end
                dbo = (sp == 2) ? 8'hA5 : 8'($urandom);
            end
        end

        // Model: each access occupies edges s .. s+S+R; strobes low after
        // edges s..s+S-1, ack after edge s+S, next grant no earlier than s+S+R+1.
        int         n;
        int         acc_s;
        int         acc_who;
        int         acc_tag;
        int         ack_tag = -1;
        int         w;
        bit         has_acc;
        bit         init_dn;
        bit         ptr;
        bit         in_stb;
        bit         ack_now;
        logic       acc_wr;
        logic [1:0] acc_addr;
        logic [7:0] acc_data;
        logic [7:0] m_rdata;
        logic [23:0] exp_vec = 24'hE00000;

        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    n = 0; has_acc = 0; init_dn = 0; ptr = 0; acc_s = 0; acc_who = 0;
                    acc_tag = -1; acc_wr = 1'b0; acc_addr = 2'b00; acc_data = 8'h00; m_rdata = 8'h00;
                end else begin
                    n++;
                    if (has_acc && acc_who != 2 && !acc_wr && n == acc_s + S) m_rdata = dbo;
                    if (has_acc && acc_who == 2 && n == acc_s + S + R) init_dn = 1;
                    if (!has_acc || n >= acc_s + S + R + 1) begin
                        if (!init_dn) begin
                            has_acc = 1; acc_s = n; acc_who = 2; acc_tag = -1;
                            acc_wr = 1'b1; acc_addr = 2'b11; acc_data = 8'h80;
                        end else if (bus_if.req_valid != 2'b00) begin
                            if (bus_if.req_valid == 2'b11) w = int'(ptr);
                            else w = bus_if.req_valid[1] ? 1 : 0;
                            ptr = (w == 0);
                            has_acc = 1; acc_s = n; acc_who = w; acc_tag = tag[w];
                            acc_wr = bus_if.req_write[w];
                            acc_addr = bus_if.req_address[w];
                            acc_data = bus_if.req_data[w];
                        end
                    end
                end
                in_stb  = has_acc && n >= acc_s && n < acc_s + S;
                ack_now = has_acc && acc_who != 2 && n == acc_s + S;
                ack_tag = ack_now ? acc_tag : -1;
                exp_vec = {!in_stb, !(in_stb && !acc_wr), !(in_stb && acc_wr), acc_addr, acc_data,
                           ack_now ? 2'(1 << acc_who) : 2'b00, m_rdata, init_dn};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cmp(0, g_cfg[0].n, g_cfg[0].ack_tag, g_cfg[0].exp_vec, g_cfg[0].act_vec);
            cmp(1, g_cfg[1].n, g_cfg[1].ack_tag, g_cfg[1].exp_vec, g_cfg[1].act_vec);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1500) @(negedge clk);
        // Abort an in-flight requester-1 strobe with an asynchronous reset.
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(posedge clk);
            #1;
            if (g_cfg[1].has_acc && g_cfg[1].acc_who == 1 &&
                g_cfg[1].n >= g_cfg[1].acc_s && g_cfg[1].n < g_cfg[1].acc_s + 3) begin
                found = 1'b1;
            end
        end
        if (!found) begin
            total++;
            $display("FAIL inst1 reset_window: got none expected req1 strobe within 2000 cycles");
        end else begin
            #1;
            rst_n = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (800) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
